btn_event_gen: RTL and testbench
================================

Name: btn_event_gen

Overview:
Converts the debounced, synchronised button level from the button filter stage into discrete one-cycle events for the calculator control FSM: press, release, long-press and auto-repeat.
- Shares the filter's CLK and CE tick, so hold timing is expressed in CE ticks.
- One instance per button.
- All outputs are registered.

Parameters:
CNT_WIDTH, 8, width of the hold/repeat tick counter
LONG_TICKS, 200, CE ticks the button must stay held in PRESSED before LONG fires; legal range 1..2^CNT_WIDTH
REPEAT_TICKS, 50, CE ticks between successive REPEAT pulses after LONG; legal range 1..2^CNT_WIDTH

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
CE  input  1  timing tick, same strobe as the filter stage's CE
BTN_IN  input  1  debounced button level from the filter stage; already synchronous to CLK
PRESS  output  1  one-CLK pulse on press
RELEASE  output  1  one-CLK pulse on release
LONG  output  1  one-CLK pulse when hold reaches LONG_TICKS
REPEAT  output  1  one-CLK auto-repeat pulse while held past LONG
HELD  output  1  level, high while the FSM is not in IDLE

Behaviour:
- Reset: asynchronous, with immediate effect at any time including mid-hold.
  - State goes to IDLE and HOLD_CNT to 0.
  - PRESS, RELEASE, LONG, REPEAT and HELD all go to 0.
  - No event is emitted on reset assertion or deassertion.
- FSM states: IDLE, PRESSED, AUTO (encoding free). The FSM samples BTN_IN directly on each CLK edge.
- IDLE:
  - BTN_IN=1 → PRESSED; PRESS=1 for the following cycle; HOLD_CNT←0.
  - BTN_IN=0 → stay in IDLE.
- PRESSED:
  - BTN_IN=0 → IDLE; RELEASE=1; HOLD_CNT←0.
  - Else if CE and HOLD_CNT==LONG_TICKS-1 → AUTO; LONG=1; HOLD_CNT←0.
  - Else if CE → HOLD_CNT+1.
  - Else hold.
- AUTO:
  - BTN_IN=0 → IDLE; RELEASE=1; HOLD_CNT←0.
  - Else if CE and HOLD_CNT==REPEAT_TICKS-1 → REPEAT=1; HOLD_CNT←0; stay in AUTO.
  - Else if CE → HOLD_CNT+1.
- Latency: each event output goes high during the CLK period immediately after the edge that made the decision, and stays high for exactly one period.
- The CE that coincides with the IDLE→PRESSED edge is not counted.
  - LONG fires on the LONG_TICKS-th CE edge strictly after the press edge.
  - Each REPEAT fires on every REPEAT_TICKS-th CE edge after the LONG edge.
- Priority: release beats a simultaneous terminal count. BTN_IN=0 on the same edge as CE at terminal count produces RELEASE only, with no LONG or REPEAT.
- Mutual exclusion: at most one of PRESS, RELEASE, LONG and REPEAT is high in any cycle.
- HELD:
  - Registered; equals 1 in exactly the cycles where the state is PRESSED or AUTO.
  - Rises together with PRESS and falls together with RELEASE.
- Counter width: compare against LONG_TICKS-1 and REPEAT_TICKS-1 truncated to CNT_WIDTH bits.
  - HOLD_CNT never exceeds the active terminal value, so it never wraps.
- Minimum press: BTN_IN high for one sampled cycle gives PRESS then RELEASE on consecutive cycles.
- Held through reset: a button held while RST deasserts produces PRESS on the first edge after release of reset.
- CE held permanently high is legal; timing then counts in CLK cycles.

Optional Feature:
Macro BTN_EVT_REPEAT_EN.
- Defined: AUTO behaves as described above, emitting periodic REPEAT pulses.
- Undefined:
  - REPEAT is tied to constant 0.
  - In AUTO, HOLD_CNT is frozen at 0 and the FSM only waits for release.
  - LONG, PRESS, RELEASE and HELD behaviour is unchanged.
  - REPEAT_TICKS is ignored.

Test Plan:
1. Short press, CNT_WIDTH=4, LONG_TICKS=8, REPEAT_TICKS=3, CE every 4 CLK. BTN_IN high for 10 CLK → PRESS one cycle after the first high sample, RELEASE one cycle after the first low sample, LONG and REPEAT never fire, HELD high for 10 cycles.
2. Long hold with BTN_EVT_REPEAT_EN defined, same parameters, BTN_IN held for 60 CE ticks → exactly one LONG on the 8th CE after press, then REPEAT on CE 11, 14, 17… (17 pulses), then RELEASE.
3. Same stimulus as test 2 with the macro undefined → one LONG, zero REPEAT, RELEASE at the end.
4. Release coinciding with a CE terminal count (BTN_IN drops on the edge of the 8th CE) → RELEASE only, no LONG, state returns to IDLE.
5. Reset mid-hold: assert RST during AUTO while BTN_IN=1 → all outputs 0 immediately. Deassert RST with BTN_IN still high → PRESS on the next edge, HOLD_CNT restarts from 0, LONG again after 8 CE ticks.
6. CE tied to 1, LONG_TICKS=1, REPEAT_TICKS=1, macro defined, BTN_IN held → PRESS, then LONG, then REPEAT every cycle; pulses never overlap.

Source files
------------

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into one-cycle PRESS / RELEASE / LONG / REPEAT events plus a HELD level.
// Optional auto-repeat is enabled by defining BTN_EVT_REPEAT_EN; without it REPEAT is tied low.
module btn_event_gen #(
    parameter int CNT_WIDTH    = 8,
    parameter int LONG_TICKS   = 200,
    parameter int REPEAT_TICKS = 50
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN_IN,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG,
    output logic REPEAT,
    output logic HELD
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_AUTO    = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LONG_TERM = CNT_WIDTH'(LONG_TICKS - 1);

    if (LONG_TICKS < 1 || LONG_TICKS > 2 ** CNT_WIDTH ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > 2 ** CNT_WIDTH) begin : g_bad_param
        $error("btn_event_gen: LONG_TICKS/REPEAT_TICKS out of range for CNT_WIDTH");
    end

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;
    logic                 held_q, held_d;
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REPEAT_TERM = CNT_WIDTH'(REPEAT_TICKS - 1);
    logic                 repeat_q, repeat_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
        repeat_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (BTN_IN) begin
                    state_d    = ST_PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over a coincident terminal count.
                if (!BTN_IN) begin
                    state_d    = ST_IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (CE) begin
                    if (hold_cnt_q == LONG_TERM) begin
                        state_d    = ST_AUTO;
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_AUTO: begin
                if (!BTN_IN) begin
                    state_d    = ST_IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end else begin
`ifdef BTN_EVT_REPEAT_EN
                    if (CE) begin
                        if (hold_cnt_q == REPEAT_TERM) begin
                            repeat_d   = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
                        end
                    end
`else
                    hold_cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            held_q     <= held_d;
        end
    end

`ifdef BTN_EVT_REPEAT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign REPEAT = repeat_q;
`else
    assign REPEAT = 1'b0;
`endif

    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign LONG    = long_q;
    assign HELD    = held_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: table vectors plus hold/release/reset sequences, scored per cycle.
module tb_btn_event_gen;

    typedef struct packed {
        logic press;
        logic rel;
        logic long_p;
        logic rpt;
        logic held;
    } out_t;

    typedef struct {
        out_t a;
        out_t b;
    } exp_t;

    typedef struct {
        logic btn;
        logic ce;
        out_t exp;
    } vec_t;

`ifdef BTN_EVT_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ce, btn_a, btn_b;
    logic a_press, a_rel, a_long, a_rpt, a_held;
    logic b_press, b_rel, b_long, b_rpt, b_held;

    always #5 clk = ~clk;

    btn_event_gen #(.CNT_WIDTH(4), .LONG_TICKS(8), .REPEAT_TICKS(3)) u_dut_a (
        .CLK(clk), .RST(rst), .CE(ce), .BTN_IN(btn_a),
        .PRESS(a_press), .RELEASE(a_rel), .LONG(a_long), .REPEAT(a_rpt), .HELD(a_held)
    );

    btn_event_gen #(.CNT_WIDTH(4), .LONG_TICKS(1), .REPEAT_TICKS(1)) u_dut_b (
        .CLK(clk), .RST(rst), .CE(ce), .BTN_IN(btn_b),
        .PRESS(b_press), .RELEASE(b_rel), .LONG(b_long), .REPEAT(b_rpt), .HELD(b_held)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    // Reference model: counts CE ticks since the press and derives events arithmetically.
    int m_held [2];
    int m_ces  [2];
    int m_long [2] = '{8, 1};
    int m_rep  [2] = '{3, 1};

    int a_long_n, a_rpt_n, a_rel_n, b_long_n, b_rpt_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic out_t model_step(input int idx, input logic btn, input logic ce_v);
        out_t o = '0;
        if (m_held[idx] == 0) begin
            if (btn) begin
                o.press     = 1'b1;
                m_held[idx] = 1;
                m_ces[idx]  = 0;
            end
        end else if (!btn) begin
            o.rel       = 1'b1;
            m_held[idx] = 0;
        end else if (ce_v) begin
            m_ces[idx]++;
            if (m_ces[idx] == m_long[idx])
                o.long_p = 1'b1;
            else if (RPT_EN && m_ces[idx] > m_long[idx] &&
                     ((m_ces[idx] - m_long[idx]) % m_rep[idx]) == 0)
                o.rpt = 1'b1;
        end
        o.held = (m_held[idx] != 0);
        return o;
    endfunction

    task automatic step(input logic b_a, input logic c, input logic b_b,
                        input bit use_tab, input out_t tab_a);
        exp_t e;
        @(negedge clk);
        btn_a = b_a;
        ce    = c;
        btn_b = b_b;
        e.a = model_step(0, b_a, c);
        if (use_tab) e.a = tab_a;
        e.b = model_step(1, b_b, c);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        ce    = 1'b0;
        m_held = '{0, 0};
        m_ces  = '{0, 0};
        a_long_n = 0; a_rpt_n = 0; a_rel_n = 0; b_long_n = 0; b_rpt_n = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard checker: pops one expectation per clock edge, sampled 1ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("a_out", {27'd0, a_press, a_rel, a_long, a_rpt, a_held}, {27'd0, e.a});
                check("b_out", {27'd0, b_press, b_rel, b_long, b_rpt, b_held}, {27'd0, e.b});
                check("a_onehot", 32'($countones({a_press, a_rel, a_long, a_rpt}) <= 1), 32'd1);
                check("b_onehot", 32'($countones({b_press, b_rel, b_long, b_rpt}) <= 1), 32'd1);
                a_long_n += int'(a_long);
                a_rpt_n  += int'(a_rpt);
                a_rel_n  += int'(a_rel);
                b_long_n += int'(b_long);
                b_rpt_n  += int'(b_rpt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tab [16];
        int   ces;
        bit   done;

        // Short press (10 cycles, CE every 4 CLK) then a one-cycle minimum press.
        tab[0]  = '{btn: 1'b0, ce: 1'b0, exp: out_t'(5'b00000)};
        tab[1]  = '{btn: 1'b1, ce: 1'b1, exp: out_t'(5'b10001)};
        for (int i = 2; i <= 10; i++)
            tab[i] = '{btn: 1'b1, ce: logic'((i % 4) == 1), exp: out_t'(5'b00001)};
        tab[11] = '{btn: 1'b0, ce: 1'b0, exp: out_t'(5'b01000)};
        tab[12] = '{btn: 1'b0, ce: 1'b0, exp: out_t'(5'b00000)};
        tab[13] = '{btn: 1'b1, ce: 1'b0, exp: out_t'(5'b10001)};
        tab[14] = '{btn: 1'b0, ce: 1'b1, exp: out_t'(5'b01000)};
        tab[15] = '{btn: 1'b0, ce: 1'b0, exp: out_t'(5'b00000)};

        rst = 1'b1; ce = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_a", {27'd0, a_press, a_rel, a_long, a_rpt, a_held}, 32'd0);
        check("reset_b", {27'd0, b_press, b_rel, b_long, b_rpt, b_held}, 32'd0);
        do_reset();

        for (int i = 0; i < 16; i++)
            step(tab[i].btn, tab[i].ce, 1'b0, 1'b1, tab[i].exp);
        drain();
        check("short_long_count", 32'(a_long_n), 32'd0);
        check("short_rel_count", 32'(a_rel_n), 32'd2);

        // Long hold for 60 CE ticks.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 240; k++)
            step(1'b1, logic'((k % 4) == 3), 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drain();
        check("hold_long_count", 32'(a_long_n), 32'd1);
        check("hold_rpt_count", 32'(a_rpt_n), RPT_EN ? 32'd17 : 32'd0);
        check("hold_rel_count", 32'(a_rel_n), 32'd1);

        // Release on the same edge as the terminal (8th) CE.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        ces  = 0;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if ((k % 4) == 3) begin
                ces++;
                if (ces == 8) begin
                    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
                    done = 1'b1;
                end else begin
                    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
                end
            end else begin
                step(1'b1, 1'b0, 1'b0, 1'b0, '0);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drain();
        check("tc_release_long_count", 32'(a_long_n), 32'd0);
        check("tc_release_rel_count", 32'(a_rel_n), 32'd1);

        // Reset asserted mid-cycle while in AUTO, released with the button still held.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 40; k++)
            step(1'b1, logic'((k % 4) == 3), 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        check("auto_before_reset_held", 32'(a_held), 32'd1);
        check("auto_before_reset_long", 32'(a_long_n), 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_a", {27'd0, a_press, a_rel, a_long, a_rpt, a_held}, 32'd0);
        m_held = '{0, 0};
        a_long_n = 0; a_rpt_n = 0; a_rel_n = 0;
        repeat (2) @(negedge clk);
        check("reset_held_a", {27'd0, a_press, a_rel, a_long, a_rpt, a_held}, 32'd0);
        rst = 1'b0;
        ce  = 1'b0;
        sb_q.push_back('{a: model_step(0, 1'b1, 1'b0), b: model_step(1, 1'b0, 1'b0)});
        for (int k = 0; k < 36; k++)
            step(1'b1, logic'((k % 4) == 3), 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drain();
        check("after_reset_long_count", 32'(a_long_n), 32'd1);

        // CE tied high, LONG_TICKS = REPEAT_TICKS = 1 on the second instance.
        do_reset();
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        drain();
        check("fast_long_count", 32'(b_long_n), 32'd1);
        check("fast_rpt_count", 32'(b_rpt_n), RPT_EN ? 32'd4 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
